// File: rtl/cpu_pkg.sv
// Shared CPU definitions: mult/div FSM state, operation select codes,
// datapath width and iteration count, and an operand-magnitude helper.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int RUN_CYCLES = 32;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } md_state_t;

    // Absolute value of a two's-complement word (0x80000000 maps to itself,
    // which is the correct unsigned magnitude)
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / divide unit producing HI/LO.
// Mult: shift-add over 32 cycles; div: restoring shift-subtract over 32
// cycles. Operands are reduced to magnitudes on LOAD and the signs are
// re-applied in FIX. HI/LO change only on the commit edge into DONE.
// Optional build macro MULT_DIV_FAST_ZERO_EN: a mult with a zero operand
// skips the iteration and commits HI=LO=0 straight from LOAD.
module mult_div_unit
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              MDcontrol,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic              Div0,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    md_state_t         state, state_nx;
    logic              op_div;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] acc_hi, acc_lo, md_b;
    logic [31:0]       cnt;
    logic              neg_q, neg_r;
    logic              div0_r;

    logic              div_zero, zero_skip, run_last;
    logic [DATA_W:0]   add_sum, rem_sh, rem_sub;
    logic              rem_ge;
    logic [DATA_W-1:0] fix_hi, fix_lo;

    assign div_zero = op_div && (op_b == '0);
`ifdef MULT_DIV_FAST_ZERO_EN
    assign zero_skip = (op_div == MD_MULT) && ((op_a == '0) || (op_b == '0));
`else
    assign zero_skip = 1'b0;
`endif
    assign run_last = (cnt == 32'(RUN_CYCLES - 1));

    // One iteration step: mult partial-sum add and div trial subtract
    assign add_sum = {1'b0, acc_hi} + {1'b0, md_b};
    assign rem_sh  = {acc_hi, acc_lo[DATA_W-1]};
    assign rem_ge  = (rem_sh >= {1'b0, md_b});
    assign rem_sub = rem_sh - {1'b0, md_b};

    // Sign correction: full 64-bit product for mult, quotient and
    // remainder negated independently for div
    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (!op_div) begin
            if (neg_q) {fix_hi, fix_lo} = ~{acc_hi, acc_lo} + 64'd1;
        end else begin
            if (neg_q) fix_lo = ~acc_lo + 1'b1;
            if (neg_r) fix_hi = ~acc_hi + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // FSM next-state; start is only looked at in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_LOAD;
            ST_LOAD: state_nx = (div_zero || zero_skip) ? ST_DONE : ST_RUN;
            ST_RUN:  if (run_last) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
        Div0 = (state == ST_DONE) && div0_r;
    end

    // Operand capture, iteration datapath and HI/LO commit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_div <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            md_b   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0_r <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a   <= A;
                        op_b   <= B;
                        op_div <= (MDcontrol == MD_DIV);
                    end
                end
                ST_LOAD: begin
                    acc_hi <= '0;
                    acc_lo <= mag(op_a);
                    md_b   <= mag(op_b);
                    neg_q  <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                    neg_r  <= op_a[DATA_W-1];
                    cnt    <= '0;
                    div0_r <= div_zero;
                    if (zero_skip) begin
                        HI <= '0;
                        LO <= '0;
                    end
                end
                ST_RUN: begin
                    if (!op_div) begin
                        if (acc_lo[0]) {acc_hi, acc_lo} <= {add_sum, acc_lo[DATA_W-1:1]};
                        else           {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[DATA_W-1:1]};
                    end else begin
                        acc_hi <= rem_ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
                        acc_lo <= {acc_lo[DATA_W-2:0], rem_ge};
                    end
                    cnt <= run_last ? '0 : cnt + 32'd1;
                end
                ST_FIX: begin
                    HI <= fix_hi;
                    LO <= fix_lo;
                end
                ST_DONE: div0_r <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO, done latency
// counted from the start-sampling edge, Div0, start ignored while busy
// and in DONE, and reset in the middle of an operation.
module tb_mult_div_unit;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        MDcontrol = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, Div0;
    logic [31:0] HI, LO;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;
    int          lat;
    int          fz_lat;
    bit          no_done;

    mult_div_unit dut (
        .clock(clock), .reset(reset), .start(start), .MDcontrol(MDcontrol),
        .A(A), .B(B), .busy(busy), .done(done), .Div0(Div0), .HI(HI), .LO(LO)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the operand inputs after sampling, wait
    // (bounded) for done and check latency, flags, results and that HI/LO
    // stayed put until the commit. With hold=1 start stays high and the task
    // returns during the DONE cycle.
    task automatic run_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input int exp_lat, input logic exp_div0,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, output int n);
        bit stable = 1'b1;
        A = a; B = b; MDcontrol = op; start = 1'b1;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        A = ~a ^ 32'h5A5A_0000; B = b + 32'd3; MDcontrol = ~op;
        n = 1;
        while (!done && n < 100) begin
            if (HI !== cur_hi || LO !== cur_lo) stable = 1'b0;
            @(posedge clock); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " hilo_stable"}, 32'(stable), 32'd1);
        chk({tag, " busy_in_done"}, 32'(busy), 32'd1);
        chk({tag, " Div0"}, 32'(Div0), 32'(exp_div0));
        chk({tag, " HI"}, HI, exp_hi);
        chk({tag, " LO"}, LO, exp_lo);
        cur_hi = exp_hi;
        cur_lo = exp_lo;
        if (!hold) begin
            @(posedge clock); #1;
            chk({tag, " done_pulse"}, 32'(done), 32'd0);
            chk({tag, " idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst Div0", 32'(Div0), 32'd0);
        chk("rst HI", HI, 32'd0);
        chk("rst LO", LO, 32'd0);

        // Start presented for the very first edge after release
        @(negedge clock);
        reset = 1'b1;
        run_op("mul 7*-3", MD_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, 35, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, lat);
        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 35, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, lat);
        run_op("div 5/0", MD_DIV, 32'd5, 32'd0, 1'b0, 2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, lat);
        run_op("mul min*min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 35, 1'b0, 32'h4000_0000, 32'h0, lat);
        run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 35, 1'b0, 32'h0, 32'h8000_0000, lat);
        run_op("div 100/7", MD_DIV, 32'd100, 32'd7, 1'b0, 35, 1'b0, 32'd2, 32'd14, lat);
        run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 35, 1'b0, 32'd1, 32'hFFFF_FFFD, lat);
        run_op("mul big*16", MD_MULT, 32'h1234_5678, 32'h10, 1'b0, 35, 1'b0, 32'h1, 32'h2345_6780, lat);
`ifdef MULT_DIV_FAST_ZERO_EN
        fz_lat = 2;
`else
        fz_lat = 35;
`endif
        run_op("mul 0*9", MD_MULT, 32'd0, 32'd9, 1'b0, fz_lat, 1'b0, 32'h0, 32'h0, lat);

        // start held high through RUN and DONE: no restart until the IDLE cycle
        run_op("mul hold", MD_MULT, 32'd3, 32'd5, 1'b1, 35, 1'b0, 32'h0, 32'd15, lat);
        A = 32'd6; B = 32'd7; MDcontrol = MD_MULT;
        @(posedge clock); #1;
        chk("start in DONE ignored", 32'(busy), 32'd0);
        @(posedge clock); #1;
        chk("start in IDLE accepted", 32'(busy), 32'd1);
        start = 1'b0;

        // Reset at RUN cycle 10 of that operation
        repeat (10) @(posedge clock);
        #1;
        chk("mid-run busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid-run rst busy", 32'(busy), 32'd0);
        chk("mid-run rst done", 32'(done), 32'd0);
        chk("mid-run rst HI", HI, 32'd0);
        chk("mid-run rst LO", LO, 32'd0);
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clock);
        reset = 1'b1;
        no_done = 1'b1;
        repeat (50) begin
            @(posedge clock); #1;
            if (done || busy) no_done = 1'b0;
        end
        chk("no done after rst", 32'(no_done), 32'd1);

        run_op("mul 6*7", MD_MULT, 32'd6, 32'd7, 1'b0, 35, 1'b0, 32'h0, 32'd42, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
